// File: rtl/hdmi_link_sequencer.sv
// HDMI link bring-up and pattern sequencer: encoder reset hold, lock wait, frame settle, then pattern select.
// All outputs registered; pattern changes land only in the cycle after a VGA_VS rising edge.
module hdmi_link_sequencer #(
  parameter int RST_HOLD_CYC  = 1024,
  parameter int SETTLE_FRAMES = 2,
  parameter int NUM_PAT       = 8,
  parameter int AUTO_FRAMES   = 0,
  parameter int PAT_W         = $clog2(NUM_PAT)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOCKED,
  input  logic             VGA_VS,
  input  logic             NEXT,
  output logic             ENC_RST,
  output logic             VIDEO_EN,
  output logic [PAT_W-1:0] PAT_SEL,
  output logic             LINK_UP
);

  localparam int HOLD_W  = $clog2(RST_HOLD_CYC + 1);
  localparam int FRM_MAX = (SETTLE_FRAMES > AUTO_FRAMES) ? SETTLE_FRAMES : AUTO_FRAMES;
  localparam int FRM_W   = (FRM_MAX < 1) ? 1 : $clog2(FRM_MAX + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYC - 1);
  localparam logic [FRM_W-1:0]  SETTLE_N  = FRM_W'(SETTLE_FRAMES);
  localparam logic [FRM_W-1:0]  AUTO_N    = FRM_W'(AUTO_FRAMES);
  localparam logic [PAT_W-1:0]  PAT_LAST  = PAT_W'(NUM_PAT - 1);

  typedef enum logic [1:0] {HOLD, WAIT_LOCK, SETTLE, RUN} state_t;

  state_t            state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  logic [FRM_W-1:0]  frame_cnt, frame_cnt_nxt;
  logic              pending, pending_nxt;
  logic [PAT_W-1:0]  pat_nxt;
  logic              vs_d;
  logic              tick;
  logic              auto_hit;
  logic              advance;

  // vs_d follows VGA_VS even in reset so a sync already high at release is not seen as an edge.
  always_ff @(posedge CLK) begin
    vs_d <= VGA_VS;
  end

  assign tick = VGA_VS & ~vs_d;

  always_comb begin
    state_nxt     = state;
    hold_cnt_nxt  = hold_cnt;
    frame_cnt_nxt = frame_cnt;
    pending_nxt   = pending;
    pat_nxt       = PAT_SEL;
    auto_hit      = 1'b0;
    advance       = 1'b0;

    case (state)
      HOLD: begin
        hold_cnt_nxt = hold_cnt + HOLD_W'(1);
        if (hold_cnt == HOLD_LAST) begin
          state_nxt    = WAIT_LOCK;
          hold_cnt_nxt = '0;
        end
      end

      WAIT_LOCK: begin
        if (LOCKED) begin
          state_nxt     = SETTLE;
          frame_cnt_nxt = '0;
        end
      end

      SETTLE: begin
        if (!LOCKED) begin
          state_nxt     = HOLD;
          hold_cnt_nxt  = '0;
          frame_cnt_nxt = '0;
          pending_nxt   = 1'b0;
        end else if ((frame_cnt == SETTLE_N) ||
                     (tick && (frame_cnt + FRM_W'(1) == SETTLE_N))) begin
          state_nxt     = RUN;
          frame_cnt_nxt = '0;
        end else if (tick) begin
          frame_cnt_nxt = frame_cnt + FRM_W'(1);
        end
      end

      RUN: begin
        if (!LOCKED) begin
          // Lock loss wins over any advance in the same cycle; the pattern is kept.
          state_nxt     = HOLD;
          hold_cnt_nxt  = '0;
          frame_cnt_nxt = '0;
          pending_nxt   = 1'b0;
        end else begin
          auto_hit = (AUTO_FRAMES > 0) && tick && (frame_cnt + FRM_W'(1) == AUTO_N);
          advance  = tick && (pending || NEXT || auto_hit);
          if (advance) begin
            pat_nxt       = (PAT_SEL == PAT_LAST) ? '0 : PAT_SEL + PAT_W'(1);
            pending_nxt   = 1'b0;
            frame_cnt_nxt = '0;
          end else begin
            if (NEXT) pending_nxt = 1'b1;
            if (tick && (AUTO_FRAMES > 0)) frame_cnt_nxt = frame_cnt + FRM_W'(1);
          end
        end
      end

      default: begin
        state_nxt    = HOLD;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= HOLD;
      hold_cnt  <= '0;
      frame_cnt <= '0;
      pending   <= 1'b0;
      PAT_SEL   <= '0;
      ENC_RST   <= 1'b1;
      VIDEO_EN  <= 1'b0;
      LINK_UP   <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_cnt_nxt;
      frame_cnt <= frame_cnt_nxt;
      pending   <= pending_nxt;
      PAT_SEL   <= pat_nxt;
      ENC_RST   <= (state_nxt == HOLD);
      VIDEO_EN  <= (state_nxt == RUN);
      LINK_UP   <= (state_nxt == RUN);
    end
  end

endmodule

// File: tb/tb_hdmi_link_sequencer.sv
// Directed bench for hdmi_link_sequencer: one manual-advance instance and one auto-advance instance.
module tb_hdmi_link_sequencer;

  localparam int PW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, rst_b, locked, vs, nxt, nxt_b;
  logic          enc_rst, video_en, link_up;
  logic [PW-1:0] pat_sel;
  logic          enc_rst_b, video_en_b, link_up_b;
  logic [PW-1:0] pat_sel_b;

  hdmi_link_sequencer #(
    .RST_HOLD_CYC(16), .SETTLE_FRAMES(2), .NUM_PAT(8), .AUTO_FRAMES(0)
  ) dut (
    .CLK(clk), .RST(rst), .LOCKED(locked), .VGA_VS(vs), .NEXT(nxt),
    .ENC_RST(enc_rst), .VIDEO_EN(video_en), .PAT_SEL(pat_sel), .LINK_UP(link_up)
  );

  hdmi_link_sequencer #(
    .RST_HOLD_CYC(16), .SETTLE_FRAMES(2), .NUM_PAT(8), .AUTO_FRAMES(3)
  ) dut_auto (
    .CLK(clk), .RST(rst_b), .LOCKED(locked), .VGA_VS(vs), .NEXT(nxt_b),
    .ENC_RST(enc_rst_b), .VIDEO_EN(video_en_b), .PAT_SEL(pat_sel_b), .LINK_UP(link_up_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL sb_empty: observed %0h expected queued entry", obs);
    end else begin
      e = exp_q.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic vs_rise();
    vs = 1'b1;
    step();
  endtask

  task automatic vs_fall();
    repeat (3) step();
    vs = 1'b0;
    repeat (4) step();
  endtask

  task automatic pulse_next(input int n);
    for (int k = 0; k < n; k++) begin
      nxt = 1'b1;
      step();
      nxt = 1'b0;
      step();
    end
  endtask

  // One frame; optional NEXT in the tick cycle; pattern compared one cycle after the tick.
  task automatic frame(input bit same_next, input bit on_b);
    vs = 1'b1;
    if (on_b) nxt_b = same_next;
    else      nxt   = same_next;
    step();
    nxt   = 1'b0;
    nxt_b = 1'b0;
    pop_chk(on_b ? pat_sel_b : pat_sel);
    vs_fall();
  endtask

  initial begin
    int hold;
    int bad;
    rst = 1'b1; rst_b = 1'b1; locked = 1'b0; vs = 1'b0; nxt = 1'b0; nxt_b = 1'b0;
    repeat (3) step();
    chk("rst_enc_rst", enc_rst, 1);
    chk("rst_video_en", video_en, 0);
    chk("rst_pat_sel", pat_sel, 0);
    chk("rst_link_up", link_up, 0);

    // Power-up: LOCKED rises at cycle 40 after release.
    rst  = 1'b0;
    hold = 0;
    for (int i = 0; i < 40; i++) begin
      if (enc_rst) hold++;
      step();
    end
    chk("powerup_hold_cycles", hold, 16);
    chk("wait_lock_enc_rst", enc_rst, 0);
    chk("wait_lock_video_en", video_en, 0);
    locked = 1'b1;
    repeat (3) step();
    vs_rise();
    chk("settle_tick1_video_en", video_en, 0);
    vs_fall();
    vs = 1'b1;
    chk("settle_tick2_pre_video_en", video_en, 0);
    step();
    chk("run_video_en", video_en, 1);
    chk("run_link_up", link_up, 1);
    chk("run_enc_rst", enc_rst, 0);
    vs_fall();

    // Manual advance 0 -> 3, then NEXT coinciding with the tick.
    for (int p = 0; p < 3; p++) begin
      pulse_next(1);
      if (p == 0) chk("mid_frame_no_change", pat_sel, 0);
      push_exp("adv_mid_frame", p + 1);
      frame(1'b0, 1'b0);
    end
    push_exp("same_cycle_adv", 4);
    frame(1'b1, 1'b0);
    push_exp("same_cycle_no_extra", 4);
    frame(1'b0, 1'b0);
    pulse_next(1);
    push_exp("adv_to_5", 5);
    frame(1'b0, 1'b0);

    // Lock loss at PAT_SEL=5 with a pending request outstanding.
    pulse_next(1);
    locked = 1'b0;
    step();
    chk("loss_enc_rst", enc_rst, 1);
    chk("loss_video_en", video_en, 0);
    chk("loss_link_up", link_up, 0);
    chk("loss_pat_sel", pat_sel, 5);
    hold = 0;
    bad  = 0;
    for (int i = 0; i < 30; i++) begin
      if (enc_rst) hold++;
      if (pat_sel !== 3'd5) bad++;
      step();
    end
    chk("relock_hold_cycles", hold, 16);
    chk("relock_pat_stable", bad, 0);
    locked = 1'b1;
    repeat (3) step();
    vs_rise();
    chk("relock_settle_video_en", video_en, 0);
    vs_fall();
    vs_rise();
    chk("relock_link_up", link_up, 1);
    chk("relock_pat_sel", pat_sel, 5);
    vs_fall();
    push_exp("pending_cleared_by_loss", 5);
    frame(1'b0, 1'b0);

    // 5 -> 7, then three NEXTs in one frame wrap to 0 exactly once.
    for (int p = 6; p < 8; p++) begin
      pulse_next(1);
      push_exp("adv_to_top", p);
      frame(1'b0, 1'b0);
    end
    pulse_next(3);
    push_exp("wrap_to_0", 0);
    frame(1'b0, 1'b0);
    push_exp("wrap_no_extra", 0);
    frame(1'b0, 1'b0);
    for (int p = 1; p < 6; p++) begin
      pulse_next(1);
      push_exp("adv_again", p);
      frame(1'b0, 1'b0);
    end

    // Reset during SETTLE with PAT_SEL=5; NEXT in WAIT_LOCK must be dropped.
    locked = 1'b0;
    repeat (20) step();
    pulse_next(1);
    locked = 1'b1;
    repeat (3) step();
    chk("settle_pat_sel", pat_sel, 5);
    rst = 1'b1;
    step();
    chk("midrst_enc_rst", enc_rst, 1);
    chk("midrst_video_en", video_en, 0);
    chk("midrst_link_up", link_up, 0);
    chk("midrst_pat_sel", pat_sel, 0);
    rst    = 1'b0;
    locked = 1'b0;
    repeat (20) step();
    pulse_next(1);
    locked = 1'b1;
    repeat (3) step();
    vs_rise();
    vs_fall();
    vs_rise();
    chk("midrst_relink", link_up, 1);
    vs_fall();
    push_exp("next_in_wait_dropped", 0);
    frame(1'b0, 1'b0);

    // Auto-advance every 3 frames; manual NEXT on tick 2 restarts the count.
    rst_b = 1'b0;
    repeat (25) step();
    vs_rise();
    vs_fall();
    vs_rise();
    chk("auto_link_up", link_up_b, 1);
    vs_fall();
    push_exp("auto_t1", 0);
    frame(1'b0, 1'b1);
    push_exp("auto_t2_manual", 1);
    frame(1'b1, 1'b1);
    push_exp("auto_t3_no_adv", 1);
    frame(1'b0, 1'b1);
    push_exp("auto_t4", 1);
    frame(1'b0, 1'b1);
    push_exp("auto_t5_adv", 2);
    frame(1'b0, 1'b1);
    push_exp("auto_t6", 2);
    frame(1'b0, 1'b1);
    push_exp("auto_t7", 2);
    frame(1'b0, 1'b1);
    push_exp("auto_t8_adv", 3);
    frame(1'b0, 1'b1);

    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
